hazard_sequencer: RTL and testbench

- Pipeline hazard and exception sequencer for the 5-stage RV32I core.
- Sits beside the decode/execute pipeline registers.
- Generates operand-forwarding selects for Execute, and load-use stalls and branch flushes for Fetch/Decode/Execute.
- Runs a trap FSM that drains the pipeline and holds it frozen when the decode-stage control unit flags an illegal opcode (IllegalOp arriving in E).

---
 rtl/hazard_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_hazard_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//
// This block is the hazard and exception sequencer for the 5-stage RV32I core.
// It sits beside the decode/execute pipeline registers and does three jobs:
//   * It produces operand-forwarding selects for Execute. Memory has priority
//     over Writeback. Register x0 is never forwarded.
//   * It produces load-use stalls and branch flushes for Fetch, Decode and
//     Execute.
//   * It runs a trap FSM with the states RUN, DRAIN and TRAP. When an illegal
//     opcode reaches Execute, the FSM lets the older M/W instructions retire.
//     It then freezes the pipeline and raises trap_valid until trap_ack
//     arrives.
//
// Ports
//   clk, rst              clock; reset is asynchronous and active-low
//   RS1_D, RS2_D          source registers of the instruction in Decode
//   RS1_E, RS2_E, RD_E    source and destination registers in Execute
//   ResultSrcE            the Execute instruction is a load
//   PCSrcE                a taken branch is resolved in Execute
//   IllegalOpE            an illegal opcode is present in Execute
//   RD_M, RegWriteM       destination register and write enable in Memory
//   RD_W, RegWriteW       destination register and write enable in Writeback
//   trap_ack              acknowledge from the trap handler
//   StallF, StallD        hold the PC / hold the IF/ID register
//   FlushD, FlushE        clear the IF/ID register / clear the ID/EX register
//   ForwardAE, ForwardBE  operand select: 00 = regfile, 01 = ResultW,
//                         10 = ALUResultM
//   trap_valid            the pipeline is drained and an illegal op is pending
//   stall_count           saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module hazard_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic             IllegalOpE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  input  logic             trap_ack,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             trap_valid,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic             trap_valid_q, trap_valid_d;
  // This flag marks the first RUN cycle after a trap. In that cycle the stale
  // fetch must be discarded.
  logic             post_trap_q, post_trap_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic             lw_stall;
  logic [1:0][4:0]  rs_e;
  logic [1:0][1:0]  fwd_sel;

  // ---------------------------------------------------------------------------
  // Forwarding. The logic is the same for both operands, so it is generated
  // once per source.
  // ---------------------------------------------------------------------------
  assign rs_e = {RS2_E, RS1_E};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] =
          (RegWriteM && (RD_M != 5'd0) && (RD_M == rs_e[gi])) ? 2'b10 :
          (RegWriteW && (RD_W != 5'd0) && (RD_W == rs_e[gi])) ? 2'b01 :
                                                               2'b00;
    end
  endgenerate

  assign lw_stall = ResultSrcE && (RD_E != 5'd0) &&
                    ((RD_E == RS1_D) || (RD_E == RS2_D));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_RUN;
      drain_q       <= 4'd0;
      trap_valid_q  <= 1'b0;
      post_trap_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      trap_valid_q  <= trap_valid_d;
      post_trap_q   <= post_trap_d;
      stall_count_q <= stall_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    trap_valid_d  = trap_valid_q;
    post_trap_d   = 1'b0;
    stall_count_d = stall_count_q;
    unique case (state_q)
      S_RUN: begin
        if (IllegalOpE) begin
          state_d = S_DRAIN;
          drain_d = 4'(DRAIN_CYCLES - 1);
        end else if (!PCSrcE && lw_stall &&
                     (stall_count_q != {CNT_W{1'b1}})) begin
          // A taken branch squashes the load-use pair, so that case is not
          // counted.
          stall_count_d = stall_count_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d      = S_TRAP;
          trap_valid_d = 1'b1;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      S_TRAP: begin
        if (trap_ack) begin
          state_d      = S_RUN;
          trap_valid_d = 1'b0;
          post_trap_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. All outputs are held at zero while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    trap_valid  = 1'b0;
    stall_count = '0;
    if (rst) begin
      ForwardAE   = fwd_sel[0];
      ForwardBE   = fwd_sel[1];
      trap_valid  = trap_valid_q;
      stall_count = stall_count_q;
      unique case (state_q)
        S_RUN: begin
          if (IllegalOpE) begin
            StallF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
          if (post_trap_q) begin
            FlushD = 1'b1;
          end
        end
        S_DRAIN, S_TRAP: begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
        default: begin
          StallF = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Testbench for hazard_sequencer.
// The stimulus process drives inputs just after each rising edge. It computes
// the expected outputs for that cycle from a reference model and pushes them
// into a scoreboard queue. The monitor process pops an entry at each falling
// edge and compares it with the DUT outputs.
module tb_hazard_sequencer;

  localparam int DRAIN = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk;
  logic rst;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic ResultSrcE, PCSrcE, IllegalOpE, RegWriteM, RegWriteW, trap_ack;
  logic StallF, StallD, FlushD, FlushE, trap_valid;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] stall_count;

  hazard_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .IllegalOpE(IllegalOpE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .trap_ack(trap_ack),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .trap_valid(trap_valid), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sf, sd, fd, fe, fa, fb, tv, sc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int txn    = 0;

  // Reference model state: the number of drain cycles still to go, whether a
  // trap is pending, whether this is the first cycle after a trap, and the
  // stall count.
  int  m_drain_left = 0;
  bit  m_in_trap    = 0;
  bit  m_after_trap = 0;
  int  m_cnt        = 0;

  function automatic int fwd(input logic [4:0] rs);
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input int id, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s txn=%0d actual=%0d required=%0d", name, id, act, req);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn %0d: SF=%0d SD=%0d FD=%0d FE=%0d FA=%0d FB=%0d TV=%0d SC=%0d",
                 e.id, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
                 trap_valid, stall_count);
        chk("StallF",      e.id, int'(StallF),      e.sf);
        chk("StallD",      e.id, int'(StallD),      e.sd);
        chk("FlushD",      e.id, int'(FlushD),      e.fd);
        chk("FlushE",      e.id, int'(FlushE),      e.fe);
        chk("ForwardAE",   e.id, int'(ForwardAE),   e.fa);
        chk("ForwardBE",   e.id, int'(ForwardBE),   e.fb);
        chk("trap_valid",  e.id, int'(trap_valid),  e.tv);
        chk("stall_count", e.id, int'(stall_count), e.sc);
      end
    end
  end

  // Run one clock cycle with the inputs currently applied: compute the
  // expectation, push it, advance the model, then move to just after the next
  // rising edge.
  task automatic step();
    exp_t e;
    bit lw;
    e = '{default: 0};
    e.id = txn++;
    lw = ResultSrcE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
    if (!rst) begin
      m_drain_left = 0; m_in_trap = 0; m_after_trap = 0; m_cnt = 0;
    end else begin
      e.fa = fwd(RS1_E);
      e.fb = fwd(RS2_E);
      e.tv = m_in_trap ? 1 : 0;
      e.sc = m_cnt;
      if (m_in_trap || m_drain_left > 0) begin
        e.sf = 1; e.sd = 1; e.fe = 1;
      end else begin
        if (IllegalOpE) begin
          e.sf = 1; e.fd = 1; e.fe = 1;
        end else if (PCSrcE) begin
          e.fd = 1; e.fe = 1;
        end else if (lw) begin
          e.sf = 1; e.sd = 1; e.fe = 1;
        end
        if (m_after_trap) e.fd = 1;
      end
      // Advance the model to the next cycle.
      if (m_in_trap) begin
        if (trap_ack) begin
          m_in_trap = 0; m_after_trap = 1;
        end
      end else if (m_drain_left > 0) begin
        m_drain_left--;
        if (m_drain_left == 0) m_in_trap = 1;
      end else begin
        m_after_trap = 0;
        if (IllegalOpE) m_drain_left = DRAIN;
        else if (!PCSrcE && lw && m_cnt < CMAX) m_cnt++;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    ResultSrcE = 0; PCSrcE = 0; IllegalOpE = 0; RegWriteM = 0; RegWriteW = 0;
    trap_ack = 0;
  endtask

  task automatic set_load_use();
    idle_inputs();
    ResultSrcE = 1; RD_E = 7; RS2_D = 7;
  endtask

  // Stimulus
  initial begin
    rst = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    // During reset, drive inputs that would otherwise stall and forward.
    set_load_use();
    RegWriteM = 1; RD_M = 3; RS1_E = 3;
    step();
    rst = 1;

    // Forwarding cases
    idle_inputs();
    RegWriteM = 1; RD_M = 5; RS1_E = 5; RegWriteW = 1; RD_W = 5;
    step();
    RD_M = 0;
    step();
    RD_M = 5; RS2_E = 5; RegWriteW = 0;
    step();

    // Load-use stall, then a cycle with no hazard, then a load to x0
    set_load_use(); step();
    idle_inputs();  step();
    set_load_use(); RD_E = 0; RS2_D = 0; step();

    // A taken branch together with a load-use pair
    set_load_use(); PCSrcE = 1; step();

    // Illegal op: drain, trap, then acknowledge
    idle_inputs(); IllegalOpE = 1; step();
    idle_inputs(); PCSrcE = 1; step();
    set_load_use(); step();
    idle_inputs(); trap_ack = 0; step();
    step();
    trap_ack = 1; step();
    idle_inputs(); step();
    step();

    // Reset while a trap is pending
    IllegalOpE = 1; step();
    idle_inputs();
    for (int i = 0; i < DRAIN + 2; i++) step();
    rst = 0; step();
    rst = 1;
    set_load_use(); step();
    idle_inputs(); step();

    // Saturate the stall counter
    set_load_use();
    for (int i = 0; i < 17; i++) step();
    idle_inputs(); step();
    rst = 0; step();
    rst = 1;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      RS1_D = 5'($urandom_range(0, 7)); RS2_D = 5'($urandom_range(0, 7));
      RS1_E = 5'($urandom_range(0, 7)); RS2_E = 5'($urandom_range(0, 7));
      RD_E  = 5'($urandom_range(0, 7)); RD_M  = 5'($urandom_range(0, 7));
      RD_W  = 5'($urandom_range(0, 7));
      ResultSrcE = ($urandom_range(0, 1) == 1);
      RegWriteM  = ($urandom_range(0, 1) == 1);
      RegWriteW  = ($urandom_range(0, 1) == 1);
      PCSrcE     = ($urandom_range(0, 7) == 0);
      IllegalOpE = ($urandom_range(0, 19) == 0);
      trap_ack   = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 99) != 0);
      step();
      rst = 1;
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
